actel_s1_scheduler: RTL and testbench
=====================================

ACTEL_S1_SCHEDULER -- requirements
Module: actel_s1_scheduler

Interface
REQ-001 Parameter: none; requester count fixed at 4, data 1 bit per requester.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 clr  input  1  reset, synchronous, active-high.
REQ-004 req  input  4  per-requester access request, bit i = requester i.
REQ-005 op  input  4  per-requester operation: 0 = write din[i] into cell, 1 = clear cell.
REQ-006 din  input  4  per-requester write data bit.
REQ-007 cell_q  input  1  current output of the shared S1 storage cell.
REQ-008 cell_load  output  1  1 = cell selects load path (sel=01), 0 = hold path (sel=00, d00 fed back from cell_q).
REQ-009 cell_data  output  1  value presented on the cell load input (d01).
REQ-010 cell_clr  output  1  clear strobe to the cell.
REQ-011 gnt  output  4  one-hot grant, all-zero when no transaction is active.
REQ-012 ack  output  4  one-cycle completion pulse to the granted requester.
REQ-013 err  output  1  one-cycle pulse with ack when read-back mismatches.
REQ-014 busy  output  1  1 in any state other than IDLE.
REQ-015 err_cnt  output  4  count of mismatches, saturating at 15.

Function
REQ-016 FSM states IDLE, LOAD, CHECK; IDLE -> LOAD when any req bit is 1; LOAD -> CHECK unconditionally; CHECK -> IDLE unconditionally.
REQ-017 In IDLE, arbitration is round-robin: winner is the first set req bit searching upward from pointer ptr (2 bits), wrapping 3 -> 0.
REQ-018 On the IDLE -> LOAD edge: gnt set one-hot to the winner; winner's op and din registered as cur_op and cur_data; expected = 0 if cur_op=1 else cur_data.
REQ-019 In LOAD: cur_op=0 -> cell_load=1, cell_data=cur_data, cell_clr=0; cur_op=1 -> cell_clr=1, cell_load=0.
REQ-020 Outside LOAD: cell_load=0, cell_clr=0 (cell holds); cell_data holds last driven value.
REQ-021 In CHECK: ack bit of the granted requester = 1 for exactly that cycle; err = (cell_q != expected).
REQ-022 On the CHECK -> IDLE edge: ptr = granted index + 1 mod 4; gnt cleared; err_cnt increments if err and err_cnt < 15.
REQ-023 Transaction latency fixed: grant at edge N, cell loaded at edge N+1, ack high during cycle N+1..N+2, next grant earliest at edge N+3.
REQ-024 req is sampled only in IDLE; req changes during LOAD/CHECK have no effect; deassertion mid-transaction does not abort it.
REQ-025 A requester holding req after its ack re-competes in the next IDLE cycle with lowest priority (ptr moved past it).
REQ-026 At most one gnt bit and one ack bit high in any cycle; ack never asserts without a matching prior gnt.
REQ-027 op and din of non-granted requesters never reach cell_data or cell_clr.

Reset
REQ-028 clr=1 at a rising edge forces IDLE, ptr=0, gnt=0, ack=0, err=0, busy=0, cell_load=0, cell_clr=0, cell_data=0, err_cnt=0, regardless of state.
REQ-029 clr in LOAD or CHECK abandons the transaction: no ack, no err, no err_cnt update; the cell is not cleared by this block.
REQ-030 clr has priority over req in the same cycle; first grant possible at the first edge after clr deasserts.

Verification
REQ-031 After reset, req=0001, op=0, din=0001, cell_q follows cell_data one edge later -> gnt=0001, cell_load=1 in LOAD with cell_data=1, ack=0001 in CHECK, err=0, ptr=1.
REQ-032 req=1111 held continuously from reset -> grants in order 0001, 0010, 0100, 1000, 0001, one every 3 cycles; never two gnt bits high.
REQ-033 req=0100, op=0100 -> LOAD drives cell_clr=1, cell_load=0; cell_q=0 in CHECK -> ack=0100, err=0.
REQ-034 Write din=1 while cell_q stuck at 0, repeated 17 times -> err pulses 17 times, err_cnt stops at 15.
REQ-035 clr asserted during LOAD of requester 2 -> next cycle IDLE, gnt=0, no ack; with req=0100 still held, requester 0 order restarts (ptr=0) so 0100 is granted at the first edge after clr drops.
REQ-036 req=0010 deasserted during LOAD -> transaction completes, ack=0010 in CHECK; no second grant follows.

Source files
------------

// File: rtl/actel_s1_scheduler.sv
// Round-robin scheduler granting four requesters write/clear access to a shared S1 cell.
// Each transaction grants, loads or clears the cell, then checks the read-back value.
module actel_s1_scheduler (
    input  logic       clk,
    input  logic       clr,
    input  logic [3:0] req,
    input  logic [3:0] op,
    input  logic [3:0] din,
    input  logic       cell_q,
    output logic       cell_load,
    output logic       cell_data,
    output logic       cell_clr,
    output logic [3:0] gnt,
    output logic [3:0] ack,
    output logic       err,
    output logic       busy,
    output logic [3:0] err_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        CHECK = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [1:0] ptr_q, ptr_d;
    logic [1:0] idx_q, idx_d;
    logic [3:0] gnt_q, gnt_d;
    logic       cur_op_q, cur_op_d;
    logic       cur_data_q, cur_data_d;
    logic       cell_data_q, cell_data_d;
    logic [3:0] err_cnt_q, err_cnt_d;

    logic       win_valid;
    logic [1:0] win_idx;
    logic       mismatch;

    // Scan downward in priority distance so the closest set bit at or above ptr wins.
    always_comb begin
        logic [1:0] cand;
        win_valid = 1'b0;
        win_idx   = ptr_q;
        for (int k = 3; k >= 0; k--) begin
            cand = ptr_q + 2'(k);
            if (req[cand]) begin
                win_valid = 1'b1;
                win_idx   = cand;
            end
        end
    end

    assign mismatch = (state_q == CHECK) && (cell_q != (cur_op_q ? 1'b0 : cur_data_q));

    always_comb begin
        // NOTE: every signal gets its hold value first so no path can infer a latch.
        state_d     = state_q;
        ptr_d       = ptr_q;
        idx_d       = idx_q;
        gnt_d       = gnt_q;
        cur_op_d    = cur_op_q;
        cur_data_d  = cur_data_q;
        cell_data_d = cell_data_q;
        err_cnt_d   = err_cnt_q;
        case (state_q)
            IDLE: begin
                if (win_valid) begin
                    state_d    = LOAD;
                    idx_d      = win_idx;
                    gnt_d      = 4'b0001 << win_idx;
                    cur_op_d   = op[win_idx];
                    cur_data_d = din[win_idx];
                    if (!op[win_idx]) cell_data_d = din[win_idx];
                end
            end
            LOAD: state_d = CHECK;
            CHECK: begin
                state_d = IDLE;
                gnt_d   = 4'b0000;
                ptr_d   = idx_q + 2'd1;
                if (mismatch && err_cnt_q != 4'd15) err_cnt_d = err_cnt_q + 4'd1;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state updates use non-blocking assignments so all registers sample pre-edge values.
    always_ff @(posedge clk) begin
        if (clr) begin
            state_q     <= IDLE;
            ptr_q       <= 2'd0;
            idx_q       <= 2'd0;
            gnt_q       <= 4'b0000;
            cur_op_q    <= 1'b0;
            cur_data_q  <= 1'b0;
            cell_data_q <= 1'b0;
            err_cnt_q   <= 4'd0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            idx_q       <= idx_d;
            gnt_q       <= gnt_d;
            cur_op_q    <= cur_op_d;
            cur_data_q  <= cur_data_d;
            cell_data_q <= cell_data_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign cell_load = (state_q == LOAD) && !cur_op_q;
    assign cell_clr  = (state_q == LOAD) && cur_op_q;
    assign cell_data = cell_data_q;
    assign gnt       = gnt_q;
    assign ack       = (state_q == CHECK) ? gnt_q : 4'b0000;
    assign err       = mismatch;
    assign busy      = (state_q != IDLE);
    assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_actel_s1_scheduler.sv
// Self-checking bench: transaction-level reference model plus directed and random stimulus.
module tb_actel_s1_scheduler;

    logic       clk = 1'b0;
    logic       clr;
    logic [3:0] req, op, din;
    logic       cell_q = 1'b0;
    logic       cell_load, cell_data, cell_clr;
    logic [3:0] gnt, ack, err_cnt;
    logic       err, busy;
    logic       stuck = 1'b0;

    int total = 0;
    int bad   = 0;

    actel_s1_scheduler dut (
        .clk(clk), .clr(clr), .req(req), .op(op), .din(din), .cell_q(cell_q),
        .cell_load(cell_load), .cell_data(cell_data), .cell_clr(cell_clr),
        .gnt(gnt), .ack(ack), .err(err), .busy(busy), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    // Behavioural S1 cell; "stuck" forces the stored bit to 0 to provoke read-back errors.
    always @(posedge clk) begin
        if (stuck)          cell_q <= 1'b0;
        else if (cell_clr)  cell_q <= 1'b0;
        else if (cell_load) cell_q <= cell_data;
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: one outstanding transaction described by its winner and age.
    bit m_active = 0;
    int m_age    = 0;
    int m_idx    = 0;
    int m_ptr    = 0;
    int m_cnt    = 0;
    bit m_op     = 0;
    bit m_data   = 0;
    bit m_cdata  = 0;

    int         cycle      = 0;
    int         err_pulses = 0;
    logic [3:0] prev_gnt   = 4'b0000;
    logic [3:0] grant_log[$];
    int         grant_cyc[$];

    task automatic step();
        logic [3:0] eg, ea;
        bit el, ec, ee, eb;
        bit found;
        eg = 4'b0; ea = 4'b0; el = 0; ec = 0; ee = 0; eb = 0;
        if (m_active) begin
            eb = 1;
            eg = 4'(1 << m_idx);
            if (m_age == 0) begin
                el = !m_op;
                ec = m_op;
            end else begin
                ea = eg;
                ee = (cell_q != (m_op ? 1'b0 : m_data));
            end
        end
        check("gnt", 8'(gnt), 8'(eg));
        check("ack", 8'(ack), 8'(ea));
        check("busy", 8'(busy), 8'(eb));
        check("cell_load", 8'(cell_load), 8'(el));
        check("cell_clr", 8'(cell_clr), 8'(ec));
        check("cell_data", 8'(cell_data), 8'(m_cdata));
        check("err", 8'(err), 8'(ee));
        check("err_cnt", 8'(err_cnt), 8'(m_cnt));

        if (err === 1'b1) err_pulses++;
        if (gnt !== 4'b0 && prev_gnt === 4'b0) begin
            grant_log.push_back(gnt);
            grant_cyc.push_back(cycle);
        end
        prev_gnt = gnt;

        if (clr) begin
            m_active = 0; m_ptr = 0; m_cnt = 0; m_cdata = 0;
        end else if (m_active) begin
            if (m_age == 1) begin
                if (ee && m_cnt < 15) m_cnt++;
                m_ptr    = (m_idx + 1) % 4;
                m_active = 0;
            end else begin
                m_age = 1;
            end
        end else if (req != 4'b0) begin
            found = 0;
            for (int k = 0; k < 4; k++) begin
                if (!found && req[(m_ptr + k) % 4]) begin
                    found = 1;
                    m_idx = (m_ptr + k) % 4;
                end
            end
            m_active = 1;
            m_age    = 0;
            m_op     = op[m_idx];
            m_data   = din[m_idx];
            if (!m_op) m_cdata = m_data;
        end

        @(posedge clk);
        #1;
        cycle++;
    endtask

    task automatic do_reset();
        clr = 1'b1;
        step();
        clr = 1'b0;
    endtask

    initial begin
        logic [3:0] exp_order[5];
        clr = 1'b1; req = 4'b0; op = 4'b0; din = 4'b0;
        @(posedge clk);
        #1;
        repeat (3) step();
        clr = 1'b0;

        // Single write by requester 0, then a two-way contest that ptr=1 must resolve to requester 1.
        req = 4'b0001; op = 4'b0000; din = 4'b0001;
        repeat (3) step();
        req = 4'b0011; din = 4'b0000;
        repeat (4) step();
        req = 4'b0000;
        step();

        // Continuous contention: strict rotation, one grant every 3 cycles.
        do_reset();
        grant_log.delete();
        grant_cyc.delete();
        req = 4'b1111; op = 4'b0000; din = 4'($urandom);
        repeat (15) step();
        exp_order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        check("grant_count", 8'(grant_log.size()), 8'd5);
        for (int i = 0; i < 5 && i < grant_log.size(); i++) begin
            check("grant_order", 8'(grant_log[i]), 8'(exp_order[i]));
            if (i > 0) check("grant_spacing", 8'(grant_cyc[i] - grant_cyc[i-1]), 8'd3);
        end
        req = 4'b0000;
        step();

        // Clear operation by requester 2.
        do_reset();
        req = 4'b0100; op = 4'b0100; din = 4'($urandom);
        repeat (3) step();
        req = 4'b0000;
        step();

        // Stuck cell: 17 failing writes saturate the error counter at 15.
        do_reset();
        stuck = 1'b1;
        err_pulses = 0;
        req = 4'b0001; op = 4'b0000; din = 4'b0001;
        repeat (51) step();
        req = 4'b0000;
        step();
        check("err_pulses", 8'(err_pulses), 8'd17);
        check("err_cnt_sat", 8'(err_cnt), 8'd15);
        stuck = 1'b0;

        // Reset during LOAD abandons the transaction; grant restarts after clr drops.
        do_reset();
        req = 4'b0100; op = 4'b0000; din = 4'b0100;
        step();
        clr = 1'b1;
        step();
        clr = 1'b0;
        repeat (4) step();
        req = 4'b0000;
        repeat (2) step();

        // Request withdrawn during LOAD still completes, with no follow-up grant.
        do_reset();
        req = 4'b0010; op = 4'b0000; din = 4'b0010;
        step();
        req = 4'b0000;
        repeat (5) step();

        // Random traffic with occasional resets and stuck-cell episodes.
        for (int n = 0; n < 600; n++) begin
            req   = 4'($urandom);
            op    = 4'($urandom);
            din   = 4'($urandom);
            clr   = ($urandom_range(0, 39) == 0);
            stuck = ($urandom_range(0, 7) == 0);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
